// File: rtl/clock_switch_pkg.sv
// Shared types and defaults for the glitch-free clock-switch sequencer.
package clock_switch_pkg;

    // Sequencer phases; DONE is not a state, it is the IDLE re-entry edge.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SWITCH   = 2'd2,
        GATE_ON  = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_NUM_CLOCKS    = 4;
    localparam int unsigned DEFAULT_SETTLE_CYCLES = 8;

endpackage

// File: rtl/settle_counter.sv
// Saturating down-counter timing each settle phase of the sequencer.
module settle_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clock_switch_sequencer.sv
// Sequences a clock-mux switch: gate old source off, settle, move select,
// settle, enable new source, settle. Runs on the always-on reference clock.
import clock_switch_pkg::*;

module clock_switch_sequencer #(
    parameter int unsigned NUM_CLOCKS    = DEFAULT_NUM_CLOCKS,
    parameter int unsigned SEL_W         = $clog2(NUM_CLOCKS),
    parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int unsigned CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [SEL_W-1:0]      io_req_sel,
    output logic [SEL_W-1:0]      io_sel,
    output logic [NUM_CLOCKS-1:0] io_gate_en,
    output logic [SEL_W-1:0]      io_cur_sel,
    output logic                  io_busy,
    output logic                  io_done,
    output logic                  io_err
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    // One extra bit so the range check never compares against an unrepresentable bound.
    localparam logic [SEL_W:0]   SEL_LIMIT   = (SEL_W + 1)'(NUM_CLOCKS);

    state_e                state, stateNext;
    logic [SEL_W-1:0]      selReg, selNext;
    logic [NUM_CLOCKS-1:0] gateReg, gateNext;
    logic [SEL_W-1:0]      curReg, curNext;
    logic [SEL_W-1:0]      targetReg, targetNext;
    logic                  doneReg, doneNext;
    logic                  errReg, errNext;
    logic                  cntLoad, cntDec, cntZero;
    logic                  accept;

    settle_counter #(
        .CNT_W(CNT_W)
    ) u_settle (
        .clock    (clock),
        .reset    (reset),
        .load     (cntLoad),
        .loadValue(SETTLE_LOAD),
        .dec      (cntDec),
        .zero     (cntZero)
    );

    assign io_req_ready = (state == IDLE) && !reset;
    assign accept       = io_req_valid && io_req_ready;

    // Next-state and next-output decode, including request range/same-source checks.
    always_comb begin
        stateNext  = state;
        selNext    = selReg;
        gateNext   = gateReg;
        curNext    = curReg;
        targetNext = targetReg;
        doneNext   = 1'b0;
        errNext    = 1'b0;
        cntLoad    = 1'b0;
        cntDec     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if ({1'b0, io_req_sel} >= SEL_LIMIT) begin
                        errNext = 1'b1;
                    end else if (io_req_sel == curReg) begin
                        doneNext = 1'b1;
                    end else begin
                        targetNext = io_req_sel;
                        gateNext   = '0;
                        cntLoad    = 1'b1;
                        stateNext  = GATE_OFF;
                    end
                end
            end
            GATE_OFF: begin
                if (cntZero) begin
                    selNext   = targetReg;
                    cntLoad   = 1'b1;
                    stateNext = SWITCH;
                end else begin
                    cntDec = 1'b1;
                end
            end
            SWITCH: begin
                if (cntZero) begin
                    gateNext  = NUM_CLOCKS'(1) << targetReg;
                    curNext   = targetReg;
                    cntLoad   = 1'b1;
                    stateNext = GATE_ON;
                end else begin
                    cntDec = 1'b1;
                end
            end
            GATE_ON: begin
                if (cntZero) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    cntDec = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and registered outputs; reset returns to source 0 regardless of phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            selReg    <= '0;
            gateReg   <= NUM_CLOCKS'(1);
            curReg    <= '0;
            targetReg <= '0;
            doneReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            state     <= stateNext;
            selReg    <= selNext;
            gateReg   <= gateNext;
            curReg    <= curNext;
            targetReg <= targetNext;
            doneReg   <= doneNext;
            errReg    <= errNext;
        end
    end

    assign io_sel     = selReg;
    assign io_gate_en = gateReg;
    assign io_cur_sel = curReg;
    assign io_busy    = (state != IDLE);
    assign io_done    = doneReg;
    assign io_err     = errReg;

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Directed bench: dutA (4 sources, S=8), dutB (4 sources, S=1), dutC (5 sources, S=8).
module tb_clock_switch_sequencer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       aValid, aReady, aBusy, aDone, aErr;
    logic [1:0] aReqSel, aSel, aCur;
    logic [3:0] aGate;

    logic       bValid, bReady, bBusy, bDone, bErr;
    logic [1:0] bReqSel, bSel, bCur;
    logic [3:0] bGate;

    logic       cValid, cReady, cBusy, cDone, cErr;
    logic [2:0] cReqSel, cSel, cCur;
    logic [4:0] cGate;

    clock_switch_sequencer #(.NUM_CLOCKS(4), .SETTLE_CYCLES(8)) dutA (
        .clock(clock), .reset(reset), .io_req_valid(aValid), .io_req_ready(aReady),
        .io_req_sel(aReqSel), .io_sel(aSel), .io_gate_en(aGate), .io_cur_sel(aCur),
        .io_busy(aBusy), .io_done(aDone), .io_err(aErr));

    clock_switch_sequencer #(.NUM_CLOCKS(4), .SETTLE_CYCLES(1)) dutB (
        .clock(clock), .reset(reset), .io_req_valid(bValid), .io_req_ready(bReady),
        .io_req_sel(bReqSel), .io_sel(bSel), .io_gate_en(bGate), .io_cur_sel(bCur),
        .io_busy(bBusy), .io_done(bDone), .io_err(bErr));

    clock_switch_sequencer #(.NUM_CLOCKS(5), .SETTLE_CYCLES(8)) dutC (
        .clock(clock), .reset(reset), .io_req_valid(cValid), .io_req_ready(cReady),
        .io_req_sel(cReqSel), .io_sel(cSel), .io_gate_en(cGate), .io_cur_sel(cCur),
        .io_busy(cBusy), .io_done(cDone), .io_err(cErr));

    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Per-cycle invariants on the back-to-back instance.
    logic       monOn = 1'b0;
    logic [1:0] bPrevSel;
    logic       bPrevReset;
    always @(negedge clock) begin
        if (monOn) begin
            checkVal("b_onehot0", 32'($onehot0(bGate)), 1);
            if (bGate != 4'b0000) checkVal("b_gate_at_sel", bGate, 4'b0001 << bSel);
            if (!bPrevReset && (bSel != bPrevSel)) checkVal("b_sel_moved_gated", bGate, 0);
            checkVal("b_done_err_excl", bDone & bErr, 0);
        end
        bPrevSel   = bSel;
        bPrevReset = reset;
    end

    initial begin
        reset = 1'b1;
        aValid = 0; aReqSel = 0;
        bValid = 0; bReqSel = 0;
        cValid = 0; cReqSel = 0;

        // 1) reset state
        step();
        step();
        checkVal("rst_ready", aReady, 0);
        checkVal("rst_gate", aGate, 4'b0001);
        checkVal("rst_sel", aSel, 0);
        checkVal("rst_busy", aBusy, 0);
        checkVal("rst_done", aDone, 0);
        checkVal("rst_err", aErr, 0);
        reset = 1'b0;
        #1;
        checkVal("post_rst_ready", aReady, 1);
        checkVal("post_rst_gate", aGate, 4'b0001);
        checkVal("post_rst_cur", aCur, 0);
        monOn = 1'b1;
        step();

        // 2) 0 -> 2 with S=8
        aValid = 1; aReqSel = 2;
        step();
        aValid = 0;
        for (int c = 1; c <= 26; c++) begin
            checkVal($sformatf("sw2_gate_c%0d", c), aGate, (c >= 17) ? 4'b0100 : 4'b0000);
            checkVal($sformatf("sw2_sel_c%0d", c), aSel, (c >= 9) ? 2 : 0);
            checkVal($sformatf("sw2_cur_c%0d", c), aCur, (c >= 17) ? 2 : 0);
            checkVal($sformatf("sw2_busy_c%0d", c), aBusy, (c <= 24) ? 1 : 0);
            checkVal($sformatf("sw2_done_c%0d", c), aDone, (c == 25) ? 1 : 0);
            checkVal($sformatf("sw2_ready_c%0d", c), aReady, (c >= 25) ? 1 : 0);
            step();
        end

        // 4) same-source request is a no-op
        aValid = 1; aReqSel = 2;
        step();
        aValid = 0;
        checkVal("noop_done", aDone, 1);
        checkVal("noop_busy", aBusy, 0);
        checkVal("noop_gate", aGate, 4'b0100);
        checkVal("noop_sel", aSel, 2);
        checkVal("noop_err", aErr, 0);
        checkVal("noop_ready", aReady, 1);
        step();
        checkVal("noop_done_clr", aDone, 0);
        checkVal("noop_busy2", aBusy, 0);

        // 3) out-of-range request on the 5-source instance
        cValid = 1; cReqSel = 5;
        step();
        cValid = 0;
        checkVal("oor_err", cErr, 1);
        checkVal("oor_done", cDone, 0);
        checkVal("oor_ready", cReady, 1);
        checkVal("oor_gate", cGate, 5'b00001);
        checkVal("oor_sel", cSel, 0);
        checkVal("oor_busy", cBusy, 0);
        step();
        checkVal("oor_err_clr", cErr, 0);
        cValid = 1; cReqSel = 7;
        step();
        cValid = 0;
        checkVal("oor7_err", cErr, 1);
        checkVal("oor7_cur", cCur, 0);
        cValid = 1; cReqSel = 4;
        step();
        cValid = 0;
        checkVal("max_legal_err", cErr, 0);
        checkVal("max_legal_busy", cBusy, 1);
        checkVal("max_legal_gate", cGate, 5'b00000);

        // 5) reset mid-switch 0 -> 3
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checkVal("pre5_cur", aCur, 0);
        aValid = 1; aReqSel = 3;
        step();
        aValid = 0;
        for (int i = 0; i < 11; i++) step();
        checkVal("mid_sel_c12", aSel, 3);
        checkVal("mid_gate_c12", aGate, 4'b0000);
        reset = 1'b1;
        step();
        checkVal("midrst_sel", aSel, 0);
        checkVal("midrst_gate", aGate, 4'b0001);
        checkVal("midrst_busy", aBusy, 0);
        checkVal("midrst_cur", aCur, 0);
        checkVal("midrst_ready", aReady, 0);
        checkVal("midrst_done", aDone, 0);
        reset = 1'b0;
        #1;
        checkVal("midrst_ready_after", aReady, 1);
        aValid = 1; aReqSel = 1;
        step();
        aValid = 0;
        checkVal("postrst_accept_gate", aGate, 4'b0000);
        checkVal("postrst_accept_busy", aBusy, 1);

        // 6) back-to-back with S=1: 0 -> 1 then 1 -> 3, valid held
        bValid = 1; bReqSel = 1;
        step();
        checkVal("b2b_c1_gate", bGate, 4'b0000);
        checkVal("b2b_c1_busy", bBusy, 1);
        checkVal("b2b_c1_ready", bReady, 0);
        bReqSel = 3;
        step();
        checkVal("b2b_c2_sel", bSel, 1);
        checkVal("b2b_c2_gate", bGate, 4'b0000);
        step();
        checkVal("b2b_c3_gate", bGate, 4'b0010);
        checkVal("b2b_c3_cur", bCur, 1);
        checkVal("b2b_c3_done", bDone, 0);
        step();
        checkVal("b2b_c4_done", bDone, 1);
        checkVal("b2b_c4_ready", bReady, 1);
        checkVal("b2b_c4_busy", bBusy, 0);
        step();
        checkVal("b2b_c5_gate", bGate, 4'b0000);
        checkVal("b2b_c5_busy", bBusy, 1);
        checkVal("b2b_c5_done", bDone, 0);
        step();
        checkVal("b2b_c6_sel", bSel, 3);
        step();
        checkVal("b2b_c7_gate", bGate, 4'b1000);
        checkVal("b2b_c7_cur", bCur, 3);
        step();
        checkVal("b2b_c8_done", bDone, 1);
        checkVal("b2b_c8_ready", bReady, 1);
        bValid = 0;
        step();
        checkVal("b2b_c9_done", bDone, 0);
        checkVal("b2b_c9_busy", bBusy, 0);
        checkVal("b2b_c9_gate", bGate, 4'b1000);
        step();

        monOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
